fetch_unit: RTL and testbench

Instruction fetch stage of the RV32I pipeline, directly upstream of the instruction RAM top. It holds the PC and issues one word request per cycle to the instruction RAM, which returns data exactly one cycle later. Returned words go into a 2-entry prefetch buffer, and the buffer head is presented to decode with its PC. The block absorbs decode stalls without losing or duplicating instructions and handles branch/jump redirects with flush.

---
 rtl/fetch_unit.sv | 88 ++++++++
 tb/tb_fetch_unit.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, one-deep outstanding instruction RAM
// request, and a 2-entry {pc, instr} prefetch buffer feeding decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  output logic              iram_request_o,
  output logic [ADDR_W-1:0] iram_address_o,
  input  logic              iram_valid_i,
  input  logic [31:0]       iram_read_data_i,
  output logic              instr_valid_o,
  output logic [31:0]       instr_o,
  output logic [31:0]       pc_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] fetch_pc;
  logic [31:0] inflight_pc;
  logic        inflight;
  logic [31:0] buf_pc    [2];
  logic [31:0] buf_instr [2];
  logic        rd_ptr;
  logic [1:0]  count;

  logic        pop;
  logic        push;
  logic        issue;
  logic        wr_ptr;
  logic [2:0]  occupancy;
  logic [31:0] req_pc;

  // Decode handshake: an instruction transfers in any cycle where
  // instr_valid_o is high and stall_i is low; instr_o/pc_o hold otherwise.
  // A redirect flushes the buffer, so a transfer in that cycle is void.
  always_comb begin
    pop       = (count != 2'd0) && !stall_i && !redirect_i;
    push      = iram_valid_i && inflight && !redirect_i;
    // Every outstanding request owns a buffer slot, so the buffer cannot overflow.
    occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    issue     = redirect_i || (occupancy < 3'd2);
    req_pc    = redirect_i ? (redirect_pc_i & ~32'h3) : fetch_pc;
    wr_ptr    = rd_ptr ^ count[0];
  end

  assign iram_request_o = issue && rst;
  assign iram_address_o = req_pc[ADDR_W+1:2];
  assign instr_valid_o  = (count != 2'd0);
  assign instr_o        = instr_valid_o ? buf_instr[rd_ptr] : NOP;
  assign pc_o           = instr_valid_o ? buf_pc[rd_ptr] : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_pc[i]    <= 32'h0;
        buf_instr[i] <= NOP;
      end
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= req_pc;
        fetch_pc    <= req_pc + 32'd4;
      end
      if (redirect_i) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) begin
          buf_pc[wr_ptr]    <= inflight_pc;
          buf_instr[wr_ptr] <= iram_read_data_i;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural instruction RAM plus a queue-based
// reference model of the fetch stage, with directed and random scenarios.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        iram_request_o;
  logic [7:0]  iram_address_o;
  logic        iram_valid_i;
  logic [31:0] iram_read_data_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  fetch_unit #(.RESET_PC(32'h0), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .iram_request_o(iram_request_o),
    .iram_address_o(iram_address_o), .iram_valid_i(iram_valid_i),
    .iram_read_data_i(iram_read_data_i), .instr_valid_o(instr_valid_o),
    .instr_o(instr_o), .pc_o(pc_o)
  );

  always #5 clk = ~clk;

  // Instruction memory and reference model state
  logic [31:0] mem [256];
  logic [63:0] m_q [$];            // {pc, instr}, head = next to decode
  logic [31:0] m_fetch_pc;
  logic        m_inflight;
  logic [31:0] m_inflight_pc;
  logic        e_issue;
  logic [31:0] e_req_pc;

  logic [73:0] exp_vec;
  logic [73:0] obs_vec;
  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  task automatic fill_mem_linear();
    for (int k = 0; k < 256; k++) mem[k] = 32'h1000 + k;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fetch_pc    = 32'h0;
    m_inflight    = 1'b0;
    m_inflight_pc = 32'h0;
  endtask

  // Apply inputs for this cycle and form the expected and observed outputs.
  task automatic drive(input logic s, input logic r, input logic [31:0] t);
    logic        v;
    logic        pop;
    logic [63:0] head;
    int          occ;
    stall_i       = s;
    redirect_i    = r;
    redirect_pc_i = t;
    #1;
    v    = (m_q.size() != 0);
    head = v ? m_q[0] : {32'h0, NOP};
    pop  = v && !s;
    occ  = m_q.size() + (m_inflight ? 1 : 0) - (pop ? 1 : 0);
    e_issue  = r || (occ < 2);
    e_req_pc = r ? {t[31:2], 2'b00} : m_fetch_pc;
    exp_vec = {v, head[31:0], head[63:32], e_issue, e_req_pc[9:2]};
    obs_vec = {instr_valid_o, instr_o, pc_o, iram_request_o, iram_address_o};
  endtask

  // Advance the model and the RAM across one rising clock edge.
  task automatic edge_step();
    logic       rq;
    logic [7:0] ad;
    rq = iram_request_o;
    ad = iram_address_o;
    if (redirect_i) begin
      m_q.delete();
    end else begin
      if (m_q.size() != 0 && !stall_i) void'(m_q.pop_front());
      if (iram_valid_i && m_inflight)
        m_q.push_back({m_inflight_pc, mem[m_inflight_pc[9:2]]});
    end
    m_inflight = e_issue;
    if (e_issue) begin
      m_inflight_pc = e_req_pc;
      m_fetch_pc    = e_req_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    iram_valid_i     = rq;
    iram_read_data_i = rq ? mem[ad] : $urandom;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    iram_valid_i = 1'b0; iram_read_data_i = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    iram_valid_i = 1'b0; iram_read_data_i = 32'h0;
    #3;
    compared++;
    if (instr_valid_o !== 1'b0) begin
      mismatched++; $display("FAIL reset_valid got=%b exp=0", instr_valid_o);
    end
    compared++;
    if (instr_o !== NOP) begin
      mismatched++; $display("FAIL reset_instr got=%h exp=%h", instr_o, NOP);
    end
    compared++;
    if (pc_o !== 32'h0) begin
      mismatched++; $display("FAIL reset_pc got=%h exp=0", pc_o);
    end
    compared++;
    if (iram_request_o !== 1'b0) begin
      mismatched++; $display("FAIL reset_request got=%b exp=0", iram_request_o);
    end
  endtask

  task automatic test_free_run();
    logic [31:0] pcs [12];
    logic [31:0] ins [12];
    logic        vs  [12];
    fill_mem_linear();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      vs[i] = instr_valid_o; pcs[i] = pc_o; ins[i] = instr_o;
      compared++;
      if (obs_vec !== exp_vec) begin
        mismatched++; $display("FAIL free_run cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      compared++;
      if (iram_request_o !== 1'b1) begin
        mismatched++; $display("FAIL free_run_req cyc=%0d got=%b exp=1", i, iram_request_o);
      end
      edge_step();
    end
    for (int i = 0; i < 12; i++) begin
      compared++;
      if ({vs[i], pcs[i], ins[i]} !== ((i < 2) ? {1'b0, 32'h0, NOP}
          : {1'b1, 32'(4 * (i - 2)), 32'(32'h1000 + i - 2)})) begin
        mismatched++;
        $display("FAIL free_run_seq cyc=%0d got=%b/%h/%h", i, vs[i], pcs[i], ins[i]);
      end
    end
  endtask

  task automatic test_stall();
    bit found = 0;
    fill_mem_linear();
    do_reset();
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_q.size() != 0 && m_q[0][63:32] == 32'h8) begin
        found = 1;
      end else begin
        drive(1'b0, 1'b0, 32'h0);
        compared++;
        if (obs_vec !== exp_vec) begin
          mismatched++; $display("FAIL stall_pre cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
        end
        edge_step();
      end
    end
    compared++;
    if (!found) begin
      mismatched++; $display("FAIL stall_timeout got=none exp=pc 8");
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      compared++;
      if (obs_vec !== exp_vec) begin
        mismatched++; $display("FAIL stall cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      compared++;
      if ({pc_o, instr_o, iram_request_o} !== {32'h8, 32'h1002, 1'b0}) begin
        mismatched++;
        $display("FAIL stall_hold cyc=%0d got=%h/%h/%b exp=8/1002/0", i, pc_o, instr_o, iram_request_o);
      end
      edge_step();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      compared++;
      if (obs_vec !== exp_vec) begin
        mismatched++; $display("FAIL stall_post cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (i < 3) begin
        compared++;
        if ({instr_valid_o, pc_o} !== {1'b1, 32'(8 + 4 * i)}) begin
          mismatched++; $display("FAIL stall_resume cyc=%0d got=%h exp=%h", i, pc_o, 8 + 4 * i);
        end
      end
      edge_step();
    end
  endtask

  task automatic test_redirect();
    bit found = 0;
    bit got_first = 0;
    logic [63:0] first;
    logic [31:0] prev_pc;
    fill_mem_linear();
    do_reset();
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_inflight && m_inflight_pc == 32'h10 && iram_valid_i) begin
        found = 1;
      end else begin
        drive(1'b0, 1'b0, 32'h0);
        compared++;
        if (obs_vec !== exp_vec) begin
          mismatched++; $display("FAIL redir_pre cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
        end
        edge_step();
      end
    end
    compared++;
    if (!found) begin
      mismatched++; $display("FAIL redir_timeout got=none exp=response 0x10");
    end
    drive(1'b0, 1'b1, 32'h42);
    compared++;
    if (obs_vec !== exp_vec) begin
      mismatched++; $display("FAIL redir got=%h exp=%h", obs_vec, exp_vec);
    end
    compared++;
    if ({iram_request_o, iram_address_o} !== {1'b1, 8'h10}) begin
      mismatched++; $display("FAIL redir_req got=%b/%h exp=1/10", iram_request_o, iram_address_o);
    end
    edge_step();
    prev_pc = 32'h0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      compared++;
      if (obs_vec !== exp_vec) begin
        mismatched++; $display("FAIL redir_post cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (instr_valid_o && !got_first) begin
        got_first = 1; first = {pc_o, instr_o};
      end
      if (instr_valid_o && pc_o == 32'h10) begin
        compared++; mismatched++;
        $display("FAIL redir_leak cyc=%0d got=pc %h exp=never 10", i, pc_o);
      end
      edge_step();
    end
    compared++;
    if (!got_first || first !== {32'h40, 32'h1010}) begin
      mismatched++; $display("FAIL redir_first got=%h exp=%h", first, {32'h40, 32'h1010});
    end
  endtask

  task automatic test_redirect_stall();
    logic [31:0] t;
    fill_mem_linear();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(i >= 4, 1'b0, 32'h0);
      compared++;
      if (obs_vec !== exp_vec) begin
        mismatched++; $display("FAIL rs_fill cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      edge_step();
    end
    t = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
    drive(1'b1, 1'b1, t);
    compared++;
    if (obs_vec !== exp_vec) begin
      mismatched++; $display("FAIL rs_redir got=%h exp=%h", obs_vec, exp_vec);
    end
    compared++;
    if ({iram_request_o, iram_address_o} !== {1'b1, t[9:2]}) begin
      mismatched++; $display("FAIL rs_req got=%b/%h exp=1/%h", iram_request_o, iram_address_o, t[9:2]);
    end
    edge_step();
    for (int i = 0; i < 6; i++) begin
      drive(i < 3, 1'b0, 32'h0);
      compared++;
      if (obs_vec !== exp_vec) begin
        mismatched++; $display("FAIL rs_post cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (i == 0) begin
        compared++;
        if (instr_valid_o !== 1'b0) begin
          mismatched++; $display("FAIL rs_flush got=%b exp=0", instr_valid_o);
        end
      end
      edge_step();
    end
  endtask

  task automatic test_wrap();
    logic [7:0]  addrs [3];
    logic [63:0] outs  [$];
    fill_mem_linear();
    for (int k = 0; k < 4; k++) mem[8'hFC + k] = $urandom;
    mem[0] = $urandom;
    drive(1'b0, 1'b1, 32'h3F8);
    addrs[0] = iram_address_o;
    compared++;
    if (obs_vec !== exp_vec) begin
      mismatched++; $display("FAIL wrap_redir got=%h exp=%h", obs_vec, exp_vec);
    end
    edge_step();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      if (i < 2) addrs[i + 1] = iram_address_o;
      if (instr_valid_o) outs.push_back({pc_o, instr_o});
      compared++;
      if (obs_vec !== exp_vec) begin
        mismatched++; $display("FAIL wrap cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      edge_step();
    end
    compared++;
    if ({addrs[0], addrs[1], addrs[2]} !== 24'hFEFF00) begin
      mismatched++; $display("FAIL wrap_addr got=%h%h%h exp=feff00", addrs[0], addrs[1], addrs[2]);
    end
    compared++;
    if (outs.size() < 3 || {outs[0], outs[1], outs[2]} !==
        {32'h3F8, mem[8'hFE], 32'h3FC, mem[8'hFF], 32'h400, mem[0]}) begin
      mismatched++; $display("FAIL wrap_out got=%0d entries, first=%h", outs.size(),
                             (outs.size() != 0) ? outs[0] : 64'h0);
    end
  endtask

  task automatic test_spurious_valid();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      compared++;
      if (obs_vec !== exp_vec) begin
        mismatched++; $display("FAIL spur_fill cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      edge_step();
    end
    iram_valid_i     = 1'b1;
    iram_read_data_i = 32'hDEAD_BEEF;
    for (int i = 0; i < 6; i++) begin
      drive(i == 0, 1'b0, 32'h0);
      compared++;
      if (obs_vec !== exp_vec) begin
        mismatched++; $display("FAIL spur cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      edge_step();
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] first;
    bit got_first = 0;
    fill_mem_linear();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      edge_step();
    end
    #2;
    rst = 1'b0;
    #1;
    compared++;
    if ({instr_valid_o, instr_o, pc_o, iram_request_o} !== {1'b0, NOP, 32'h0, 1'b0}) begin
      mismatched++;
      $display("FAIL async_reset got=%b/%h/%h/%b exp=0/%h/0/0", instr_valid_o, instr_o, pc_o, iram_request_o, NOP);
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    iram_valid_i     = 1'b1;
    iram_read_data_i = 32'hBAD0_BAD0;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      compared++;
      if (obs_vec !== exp_vec) begin
        mismatched++; $display("FAIL async_restart cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (instr_valid_o && !got_first) begin
        got_first = 1; first = {pc_o, instr_o};
      end
      edge_step();
    end
    compared++;
    if (!got_first || first !== {32'h0, 32'h1000}) begin
      mismatched++; $display("FAIL async_first got=%h exp=%h", first, {32'h0, 32'h1000});
    end
  endtask

  task automatic test_random();
    logic        s;
    logic        r;
    logic [31:0] t;
    for (int k = 0; k < 256; k++) mem[k] = $urandom;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      s = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 5);
      t = $urandom;
      drive(s, r, t);
      compared++;
      if (obs_vec !== exp_vec) begin
        mismatched++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      edge_step();
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_spurious_valid();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
